axis_seq_checker: RTL and testbench
===================================

# axis_seq_checker

Synthesizable AXI-Stream sink that terminates the output of an AXI-Stream source or FIFO under test. It consumes beats through an `s_axis` port and applies pseudo-random backpressure. It checks that the data follows an incrementing sequence, counts beats and errors, and flags a stalled stream with a watchdog. This gives the on-chip equivalent of the bench-side sink and hang detector for the `axis_fifo` family.

## Interface

Parameters:
- `AXI_DATA_WIDTH`, 32: tdata width. Legal range is 8..64.
- `READY_DENSITY`, 16: backpressure strength, 0..16. tready is asserted when `lfsr[3:0] < READY_DENSITY`.
  - 16 means always ready.
  - 0 means never ready.
- `READY_SEED`, 16'hACE1: reset value of the backpressure LFSR. Must be non-zero.
- `ERR_RESYNC`, 4: number of consecutive mismatches that forces a resync. Range 1..15.
- `HANG_CYCLES`, 1024: watchdog threshold in cycles. Must be at least 2.

Ports:
- `aclk`  in  1  clock. Single clock domain.
- `aresetn`  in  1  reset. Asynchronous assert, active-low.
- `s_axis`  axis_if slave  `AXI_DATA_WIDTH`  stream input. Uses tdata, tvalid and tready; tready is driven by this block.
- `enable`  in  1  when low, tready is forced low and the watchdog is held at 0.
- `clr`  in  1  synchronous clear of counters, `hang` and lock state.
- `locked`  out  1  high once the first beat has seeded the expected value.
- `data_err`  out  1  one-cycle pulse for each mismatched beat.
- `err_count`  out  16  mismatched beats; saturates at 16'hFFFF.
- `beat_count`  out  32  accepted beats; wraps modulo 2^32.
- `hang`  out  1  sticky stall flag.

## Operation

Handshake:
- A beat is accepted when tvalid & tready are both high at a rising edge of aclk.
- tready is a register output and has no combinational path from tvalid.

Backpressure LFSR:
- 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- Advances every cycle while `enable` is high.
- The registered tready is `enable & (lfsr[3:0] < READY_DENSITY)`, computed from the current LFSR state.

State machine with two states, SEARCH and LOCKED:
- SEARCH:
  - The first accepted beat loads `expected = tdata + 1` modulo 2^AXI_DATA_WIDTH.
  - It increments `beat_count` and moves to LOCKED.
  - No comparison is made on this beat.
- LOCKED, on each accepted beat:
  - Compare tdata against `expected`.
  - `expected` advances by 1 whether or not the beat matches, so a single corrupted beat costs exactly one error.
  - `beat_count` increments on every accepted beat.
- LOCKED, on a mismatch:
  - Pulse `data_err` and increment `err_count` (saturating).
  - Increment the consecutive-mismatch counter.
- LOCKED, on a match: reset the consecutive-mismatch counter to 0.
- Resync: on the `ERR_RESYNC`-th consecutive mismatch, that beat still counts as an error. Then `expected` is reloaded to `tdata + 1` and the mismatch counter is cleared, so dropped or duplicated beats recover.
- Wrap-around: `expected` wraps from all-ones to 0 without error.

Watchdog:
- Counts consecutive cycles in LOCKED with `enable` high and no accepted beat.
- Resets to 0 on every accepted beat and whenever `enable` is low.
- `hang` sets when the count reaches `HANG_CYCLES`. It stays set until `clr` or reset; the count saturates.

`clr`:
- Returns the state machine to SEARCH.
- Zeroes `err_count`, `beat_count`, the watchdog, the mismatch counter and `hang`.
- Does not reset the backpressure LFSR.
- If `clr` coincides with a handshake, the beat is discarded: it is not counted and does not seed.

## Timing

- Reset values:
  - tready = 0, `locked` = 0, `data_err` = 0, `err_count` = 0, `beat_count` = 0, `hang` = 0.
  - LFSR = `READY_SEED`; state = SEARCH.
- All outputs are registered and update at the edge following the accepted beat, so latency is 1 cycle.
  - `data_err` is high for exactly one cycle per bad beat.
  - Back-to-back bad beats give a continuous high.
- tready updates one cycle after an `enable` change.
- Reset asserted mid-stream drops tready asynchronously. No beat is accepted at an edge where aresetn is low.
- `hang` asserts at the edge on which the watchdog count equals `HANG_CYCLES`.

## Test plan

- Reset with tvalid high -> tready = 0 and every output at its reset value. After release with `enable` = 1 and `READY_DENSITY` = 16, tready = 1 from the second edge onward.
- Drive 100 beats 0x10..0x73 with always-ready -> `locked` = 1 after the first beat, `beat_count` = 100, `err_count` = 0, `data_err` never pulses.
- Drive sequence 5,6,0xFF,8,9 -> one `data_err` pulse on the 0xFF beat and `err_count` = 1. 8 and 9 are accepted with no further error.
- Drop one beat (1,2,4,5,6,7,8) with `ERR_RESYNC` = 4:
  - Errors on 4,5,6,7, so `err_count` = 4.
  - The resync happens on 7, and 8 is clean.
- Wrap: with `AXI_DATA_WIDTH` = 8, drive 0xFE,0xFF,0x00,0x01 -> `err_count` = 0, `beat_count` = 4.
- Watchdog and clear, with `HANG_CYCLES` = 16:
  - Lock, then hold tvalid low for 16 cycles -> `hang` = 1 and it stays high.
  - Pulse `clr` -> `hang` = 0, `locked` = 0, `beat_count` = 0.
  - With `READY_DENSITY` = 0 -> tready never asserts and `beat_count` stays 0.

Source files
------------

// File: rtl/axis_if.sv
// AXI-Stream bundle carrying the tdata/tvalid/tready subset.
interface axis_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink with LFSR backpressure: checks an incrementing data sequence,
// counts beats/errors and flags a stalled stream with a sticky watchdog.
module axis_seq_checker #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          READY_DENSITY  = 16,
    parameter logic [15:0] READY_SEED     = 16'hACE1,
    parameter int          ERR_RESYNC     = 4,
    parameter int          HANG_CYCLES    = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    axis_if.slave       s_axis,
    input  logic        enable,
    input  logic        clr,
    output logic        locked,
    output logic        data_err,
    output logic [15:0] err_count,
    output logic [31:0] beat_count,
    output logic        hang
);
    localparam int WDW = $clog2(HANG_CYCLES + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t                    state, state_nxt;
    logic [15:0]               lfsr;
    logic                      tready;
    logic [AXI_DATA_WIDTH-1:0] expected;
    logic [3:0]                mis_cnt;
    logic [WDW-1:0]            wd;
    logic                      acc, mismatch, resync, wd_run;

    assign s_axis.tready = tready;
    assign locked        = (state == LOCKED);
    // A beat coinciding with clr is dropped: neither counted nor used as a seed.
    assign acc           = s_axis.tvalid & tready & ~clr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr   <= READY_SEED;
            tready <= 1'b0;
        end else begin
            if (enable)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tready <= enable & ({1'b0, lfsr[3:0]} < 5'(READY_DENSITY));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= SEARCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mismatch  = 1'b0;
        resync    = 1'b0;
        wd_run    = enable & (state == LOCKED) & ~acc;
        if (clr) begin
            state_nxt = SEARCH;
        end else if (acc) begin
            case (state)
                SEARCH: state_nxt = LOCKED;
                LOCKED: begin
                    if (s_axis.tdata != expected) begin
                        mismatch = 1'b1;
                        resync   = (mis_cnt == 4'(ERR_RESYNC - 1));
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            expected   <= '0;
            mis_cnt    <= '0;
            data_err   <= 1'b0;
            err_count  <= '0;
            beat_count <= '0;
            wd         <= '0;
            hang       <= 1'b0;
        end else if (clr) begin
            mis_cnt    <= '0;
            data_err   <= 1'b0;
            err_count  <= '0;
            beat_count <= '0;
            wd         <= '0;
            hang       <= 1'b0;
        end else begin
            data_err <= mismatch;
            if (acc) begin
                beat_count <= beat_count + 32'd1;
                // Expected advances even on a bad beat so one corrupt word costs one error.
                if (state == SEARCH || resync)
                    expected <= s_axis.tdata + AXI_DATA_WIDTH'(1);
                else
                    expected <= expected + AXI_DATA_WIDTH'(1);
                if (mismatch) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    mis_cnt <= resync ? 4'd0 : mis_cnt + 4'd1;
                end else begin
                    mis_cnt <= '0;
                end
            end
            if (wd_run) begin
                if (wd != WDW'(HANG_CYCLES)) wd <= wd + WDW'(1);
                if (wd == WDW'(HANG_CYCLES - 1)) hang <= 1'b1;
            end else begin
                wd <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axis_seq_checker.sv
// Bench for axis_seq_checker: always-ready, never-ready and random-backpressure instances.
module tb_axis_seq_checker;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_if #(.DATA_WIDTH(8))  ax_a ();
    axis_if #(.DATA_WIDTH(8))  ax_b ();
    axis_if #(.DATA_WIDTH(32)) ax_c ();

    logic        en_a, clr_a, locked_a, data_err_a, hang_a;
    logic        en_b, clr_b, locked_b, data_err_b, hang_b;
    logic        en_c, clr_c, locked_c, data_err_c, hang_c;
    logic [15:0] err_count_a, err_count_b, err_count_c;
    logic [31:0] beat_count_a, beat_count_b, beat_count_c;

    axis_seq_checker #(.AXI_DATA_WIDTH(8), .READY_DENSITY(16), .ERR_RESYNC(4), .HANG_CYCLES(16)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .s_axis(ax_a), .enable(en_a), .clr(clr_a),
        .locked(locked_a), .data_err(data_err_a), .err_count(err_count_a),
        .beat_count(beat_count_a), .hang(hang_a));

    axis_seq_checker #(.AXI_DATA_WIDTH(8), .READY_DENSITY(0), .HANG_CYCLES(16)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .s_axis(ax_b), .enable(en_b), .clr(clr_b),
        .locked(locked_b), .data_err(data_err_b), .err_count(err_count_b),
        .beat_count(beat_count_b), .hang(hang_b));

    axis_seq_checker #(.AXI_DATA_WIDTH(32), .READY_DENSITY(8)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .s_axis(ax_c), .enable(en_c), .clr(clr_c),
        .locked(locked_c), .data_err(data_err_c), .err_count(err_count_c),
        .beat_count(beat_count_c), .hang(hang_c));

    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic [15:0] errs;
        logic [31:0] beats;
    } vec_t;

    vec_t tbl[16];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic send_a(input vec_t v);
        vec_t e;
        ax_a.tvalid = 1'b1;
        ax_a.tdata  = v.data;
        sb.push_back(v);
        chk("a_tready_pre", ax_a.tready, 1);
        @(posedge aclk); #1;
        e = sb.pop_front();
        chk("a_data_err", data_err_a, e.err);
        chk("a_err_count", err_count_a, e.errs);
        chk("a_beat_count", beat_count_a, e.beats);
        chk("a_locked", locked_a, 1);
    endtask

    task automatic clr_pulse_a();
        clr_a = 1'b1;
        @(posedge aclk); #1;
        clr_a = 1'b0;
        chk("a_clr_locked", locked_a, 0);
        chk("a_clr_beats", beat_count_a, 0);
        chk("a_clr_errs", err_count_a, 0);
        chk("a_clr_hang", hang_a, 0);
    endtask

    task automatic run_a();
        int grp_lo[3] = '{0, 5, 12};
        int grp_hi[3] = '{4, 11, 15};
        @(posedge aclk); @(posedge aclk); #1;
        chk("a_tready_after_rst", ax_a.tready, 1);
        chk("a_search_no_hang", hang_a, 0);
        for (int i = 0; i < 100; i++)
            send_a('{8'(8'h10 + i), 1'b0, 16'd0, 32'(i + 1)});
        ax_a.tvalid = 1'b0;
        chk("a_100_beats", beat_count_a, 100);
        clr_pulse_a();
        for (int g = 0; g < 3; g++) begin
            for (int k = grp_lo[g]; k <= grp_hi[g]; k++) send_a(tbl[k]);
            ax_a.tvalid = 1'b0;
            if (g < 2) clr_pulse_a();
        end
        // Locked after the wrap group; idle until the watchdog fires.
        repeat (15) @(posedge aclk);
        #1 chk("a_hang_before", hang_a, 0);
        @(posedge aclk); #1;
        chk("a_hang_set", hang_a, 1);
        repeat (4) @(posedge aclk);
        #1 chk("a_hang_sticky", hang_a, 1);
        clr_pulse_a();
        // clr on a handshake discards the beat
        ax_a.tvalid = 1'b1;
        ax_a.tdata  = 8'h40;
        clr_a       = 1'b1;
        @(posedge aclk); #1;
        clr_a       = 1'b0;
        ax_a.tvalid = 1'b0;
        chk("a_clrbeat_locked", locked_a, 0);
        chk("a_clrbeat_beats", beat_count_a, 0);
        send_a('{8'h50, 1'b0, 16'd0, 32'd1});
        send_a('{8'h52, 1'b1, 16'd1, 32'd2});
        ax_a.tvalid = 1'b0;
        en_a = 1'b0;
        @(posedge aclk); #1;
        chk("a_en_low_tready", ax_a.tready, 0);
        repeat (20) @(posedge aclk);
        #1 chk("a_en_low_no_hang", hang_a, 0);
        en_a = 1'b1;
        @(posedge aclk); #1;
        chk("a_en_high_tready", ax_a.tready, 1);
        chk("a_en_high_no_hang", hang_a, 0);
    endtask

    task automatic run_b();
        ax_b.tvalid = 1'b1;
        ax_b.tdata  = 8'h33;
        for (int i = 0; i < 40; i++) begin
            @(posedge aclk); #1;
            chk("b_tready", ax_b.tready, 0);
        end
        chk("b_beats", beat_count_b, 0);
        chk("b_locked", locked_b, 0);
    endtask

    task automatic run_c();
        logic [15:0] m = 16'hACE1;
        logic [31:0] d = 32'hFFFF_FFF0;
        logic [31:0] exp_beats = 0;
        logic        vld = 1'b0;
        logic        rdy_before, exp_rdy;
        for (int i = 0; i < 300; i++) begin
            rdy_before = ax_c.tready;
            @(posedge aclk);
            exp_rdy = (m[3:0] < 4'd8);
            m = lfsr_step(m);
            #1;
            if (vld && rdy_before) begin
                exp_beats++;
                d++;
            end
            chk("c_tready", ax_c.tready, exp_rdy);
            chk("c_beats", beat_count_c, exp_beats);
            vld = ($urandom_range(0, 3) != 0);
            ax_c.tvalid = vld;
            ax_c.tdata  = d;
        end
        ax_c.tvalid = 1'b0;
        chk("c_err_count", err_count_c, 0);
        chk("c_locked", locked_c, exp_beats != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h05, 1'b0, 16'd0, 32'd1};
        tbl[1]  = '{8'h06, 1'b0, 16'd0, 32'd2};
        tbl[2]  = '{8'hFF, 1'b1, 16'd1, 32'd3};
        tbl[3]  = '{8'h08, 1'b0, 16'd1, 32'd4};
        tbl[4]  = '{8'h09, 1'b0, 16'd1, 32'd5};
        tbl[5]  = '{8'h01, 1'b0, 16'd0, 32'd1};
        tbl[6]  = '{8'h02, 1'b0, 16'd0, 32'd2};
        tbl[7]  = '{8'h04, 1'b1, 16'd1, 32'd3};
        tbl[8]  = '{8'h05, 1'b1, 16'd2, 32'd4};
        tbl[9]  = '{8'h06, 1'b1, 16'd3, 32'd5};
        tbl[10] = '{8'h07, 1'b1, 16'd4, 32'd6};
        tbl[11] = '{8'h08, 1'b0, 16'd4, 32'd7};
        tbl[12] = '{8'hFE, 1'b0, 16'd0, 32'd1};
        tbl[13] = '{8'hFF, 1'b0, 16'd0, 32'd2};
        tbl[14] = '{8'h00, 1'b0, 16'd0, 32'd3};
        tbl[15] = '{8'h01, 1'b0, 16'd0, 32'd4};

        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        ax_a.tvalid = 1'b1; ax_a.tdata = 8'h11;
        ax_b.tvalid = 1'b1; ax_b.tdata = 8'h22;
        ax_c.tvalid = 1'b1; ax_c.tdata = 32'h33;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", ax_a.tready, 0);
        chk("rst_locked", locked_a, 0);
        chk("rst_data_err", data_err_a, 0);
        chk("rst_err_count", err_count_a, 0);
        chk("rst_beat_count", beat_count_a, 0);
        chk("rst_hang", hang_a, 0);
        chk("rst_tready_c", ax_c.tready, 0);
        @(negedge aclk);
        ax_a.tvalid = 1'b0;
        ax_c.tvalid = 1'b0;
        aresetn = 1'b1;
        fork
            run_a();
            run_b();
            run_c();
        join

        // Reset mid-stream drops tready without waiting for a clock edge.
        ax_a.tvalid = 1'b1;
        ax_a.tdata  = 8'h60;
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        chk("midrst_tready", ax_a.tready, 0);
        chk("midrst_locked", locked_a, 0);
        @(posedge aclk); #1;
        chk("midrst_beats", beat_count_a, 0);
        ax_a.tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
